// File: rtl/serial_transmitter_param.sv
// Length-prefixed serial forwarder: takes a LEN_W-bit header on serIn, then passes that many
// payload bits to serOut with a one-cycle register stage, optionally followed by even parity.
module serial_transmitter_param #(
  parameter int LEN_W     = 3,
  parameter int HDR_MSB   = 1,
  parameter int PARITY_EN = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         serIn,
  output logic                         serOut,
  output logic                         out_valid,
  output logic                         par_bit,
  output logic                         Ready,
  output logic [$clog2(LEN_W+1)-1:0]   upcounter,
  output logic [LEN_W-1:0]             downcounter,
  output logic [LEN_W-1:0]             register
);

  localparam int UC_W = $clog2(LEN_W+1);

  typedef enum logic [1:0] {IDLE, HDR, XMIT, PAR} state_t;

  state_t           state;
  logic             par_acc;
  logic [LEN_W-1:0] hdr_next;
  logic             hdr_last;

  // Header register after absorbing this cycle's serIn; LEN_W must be >= 2.
  generate
    if (HDR_MSB != 0) begin : g_msb_first
      assign hdr_next = {register[LEN_W-2:0], serIn};
    end else begin : g_lsb_first
      assign hdr_next = {serIn, register[LEN_W-1:1]};
    end
  endgenerate

  assign hdr_last = (upcounter == UC_W'(LEN_W-1));
  assign Ready    = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      serOut      <= 1'b0;
      out_valid   <= 1'b0;
      par_bit     <= 1'b0;
      upcounter   <= '0;
      downcounter <= '0;
      register    <= '0;
      par_acc     <= 1'b0;
    end else begin
      serOut    <= 1'b0;
      out_valid <= 1'b0;
      par_bit   <= 1'b0;
      case (state)
        IDLE: begin
          upcounter <= '0;
          register  <= '0;
          par_acc   <= 1'b0;
          if (start) state <= HDR;
        end
        HDR: begin
          register  <= hdr_next;
          upcounter <= upcounter + UC_W'(1);
          if (hdr_last) begin
            downcounter <= hdr_next;
            if (hdr_next != '0)      state <= XMIT;
            else if (PARITY_EN != 0) state <= PAR;
            else                     state <= IDLE;
          end
        end
        XMIT: begin
          serOut    <= serIn;
          out_valid <= 1'b1;
          par_acc   <= par_acc ^ serIn;
          if (downcounter != '0) downcounter <= downcounter - LEN_W'(1);
          if (downcounter == LEN_W'(1)) state <= (PARITY_EN != 0) ? PAR : IDLE;
        end
        PAR: begin
          serOut    <= par_acc;
          out_valid <= 1'b1;
          par_bit   <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_transmitter_param.sv
// Bench for serial_transmitter_param: three configurations, frame-level reference model,
// a vector table of fixed frames plus randomized frames and reset / held-start sequences.
module tb_serial_transmitter_param;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start_v, ser_v;
  logic [2:0] so, ov, pb, rdy;
  logic [1:0] uc0, uc1;
  logic [2:0] uc2;
  logic [2:0] dc0, dc1, rg0, rg1;
  logic [3:0] dc2, rg2;

  int checks = 0;
  int errors = 0;

  serial_transmitter_param #(.LEN_W(3), .HDR_MSB(1), .PARITY_EN(0)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .serIn(ser_v[0]), .serOut(so[0]),
    .out_valid(ov[0]), .par_bit(pb[0]), .Ready(rdy[0]), .upcounter(uc0),
    .downcounter(dc0), .register(rg0));
  serial_transmitter_param #(.LEN_W(3), .HDR_MSB(1), .PARITY_EN(1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .serIn(ser_v[1]), .serOut(so[1]),
    .out_valid(ov[1]), .par_bit(pb[1]), .Ready(rdy[1]), .upcounter(uc1),
    .downcounter(dc1), .register(rg1));
  serial_transmitter_param #(.LEN_W(4), .HDR_MSB(0), .PARITY_EN(0)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .serIn(ser_v[2]), .serOut(so[2]),
    .out_valid(ov[2]), .par_bit(pb[2]), .Ready(rdy[2]), .upcounter(uc2),
    .downcounter(dc2), .register(rg2));

  function automatic int lw(int i);  return (i == 2) ? 4 : 3; endfunction
  function automatic bit msb(int i); return (i != 2);         endfunction
  function automatic bit pe(int i);  return (i == 1);         endfunction

  function automatic int get_uc(int i);
    case (i) 0: return int'(uc0); 1: return int'(uc1); default: return int'(uc2); endcase
  endfunction
  function automatic int get_dc(int i);
    case (i) 0: return int'(dc0); 1: return int'(dc1); default: return int'(dc2); endcase
  endfunction
  function automatic int get_rg(int i);
    case (i) 0: return int'(rg0); 1: return int'(rg1); default: return int'(rg2); endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Quiet cycles: every instance must sit in IDLE with cleared outputs.
  task automatic idle(input int k);
    for (int c = 0; c < k; c++) begin
      start_v = '0;
      ser_v   = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("idle i%0d rdy", i), int'(rdy[i]), 1);
        chk($sformatf("idle i%0d ov", i),  int'(ov[i]),  0);
        chk($sformatf("idle i%0d so", i),  int'(so[i]),  0);
        chk($sformatf("idle i%0d pb", i),  int'(pb[i]),  0);
        chk($sformatf("idle i%0d uc", i),  get_uc(i),    0);
        chk($sformatf("idle i%0d rg", i),  get_rg(i),    0);
      end
    end
  endtask

  // One complete frame on instance i. Expected per-cycle outputs follow from frame position:
  // cycle 0 = start, 1..L = header, L+1..L+N = payload, then optional parity cycle.
  task automatic run_frame(input int i, input int hdr, input bit [15:0] pay, input bit hold,
                           output bit [15:0] got, output int nv, output int gpar, output int np);
    int l, n, p, t, par, eso, ev, epb, erdy, euc, erg, edc;
    l = lw(i); n = hdr; p = pe(i) ? 1 : 0; t = 1 + l + n + p;
    par = 0;
    for (int k = 0; k < n; k++) par ^= int'(pay[k]);
    got = '0; nv = 0; gpar = 0; np = 0;
    chk($sformatf("i%0d pre rdy", i), int'(rdy[i]), 1);
    for (int c = 0; c < t; c++) begin
      start_v    = '0;
      start_v[i] = (c == 0) ? 1'b1 : (hold ? 1'b1 : 1'($urandom_range(0, 1)));
      ser_v      = 3'($urandom_range(0, 7));
      if (c >= 1 && c <= l)
        ser_v[i] = msb(i) ? 1'((hdr >> (l - c)) & 1) : 1'((hdr >> (c - 1)) & 1);
      else if (c > l && c <= l + n)
        ser_v[i] = pay[c-l-1];
      @(posedge clk); #1;
      ev   = (c > l && c <= l + n + p) ? 1 : 0;
      epb  = (p == 1 && c == l + n + 1) ? 1 : 0;
      eso  = (c > l && c <= l + n) ? int'(pay[c-l-1]) : (epb == 1 ? par : 0);
      erdy = (c == t - 1) ? 1 : 0;
      euc  = (c <= l) ? c : l;
      if (c == 0)     erg = 0;
      else if (c < l) erg = msb(i) ? (hdr >> (l - c)) : ((hdr & ((1 << c) - 1)) << (l - c));
      else            erg = hdr;
      edc  = (c < l) ? 0 : ((c <= l + n) ? n - (c - l) : 0);
      chk($sformatf("i%0d h%0d c%0d ov", i, hdr, c),  int'(ov[i]),  ev);
      chk($sformatf("i%0d h%0d c%0d pb", i, hdr, c),  int'(pb[i]),  epb);
      chk($sformatf("i%0d h%0d c%0d so", i, hdr, c),  int'(so[i]),  eso);
      chk($sformatf("i%0d h%0d c%0d rdy", i, hdr, c), int'(rdy[i]), erdy);
      chk($sformatf("i%0d h%0d c%0d uc", i, hdr, c),  get_uc(i),    euc);
      chk($sformatf("i%0d h%0d c%0d rg", i, hdr, c),  get_rg(i),    erg);
      chk($sformatf("i%0d h%0d c%0d dc", i, hdr, c),  get_dc(i),    edc);
      if (ov[i] && !pb[i] && nv < 16) begin got[nv] = so[i]; nv++; end
      if (ov[i] && pb[i]) begin gpar = int'(so[i]); np++; end
    end
    start_v = '0;
  endtask

  typedef struct {
    int        inst;
    int        hdr;
    bit [15:0] pay;        // bit k = k-th payload bit on the wire
    int        exp_n;
    bit [15:0] exp_stream;
    int        exp_np;
    int        exp_par;
  } vec_t;

  vec_t      vecs[7];
  bit [15:0] got;
  int        nv, gpar, np;

  initial begin
    vecs[0] = '{0, 5,  16'h0013, 5,  16'h0013, 0, 0};  // header 1,0,1 payload 1,1,0,0,1
    vecs[1] = '{1, 3,  16'h0005, 3,  16'h0005, 1, 0};  // header 0,1,1 payload 1,0,1
    vecs[2] = '{0, 0,  16'h0000, 0,  16'h0000, 0, 0};  // empty frame, no parity
    vecs[3] = '{1, 0,  16'h0000, 0,  16'h0000, 1, 0};  // empty frame, parity only
    vecs[4] = '{2, 15, 16'h5A3C, 15, 16'h5A3C, 0, 0};  // LSB-first all-ones header
    vecs[5] = '{1, 7,  16'h006B, 7,  16'h006B, 1, 1};  // max payload, odd ones count
    vecs[6] = '{2, 1,  16'h0001, 1,  16'h0001, 0, 0};  // shortest non-empty payload

    rst = 1'b1; start_v = '0; ser_v = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst i%0d rdy", i), int'(rdy[i]), 1);
      chk($sformatf("rst i%0d ov", i),  int'(ov[i]),  0);
      chk($sformatf("rst i%0d so", i),  int'(so[i]),  0);
      chk($sformatf("rst i%0d pb", i),  int'(pb[i]),  0);
      chk($sformatf("rst i%0d uc", i),  get_uc(i),    0);
      chk($sformatf("rst i%0d dc", i),  get_dc(i),    0);
      chk($sformatf("rst i%0d rg", i),  get_rg(i),    0);
    end
    rst = 1'b0;
    idle(1);

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].inst, vecs[v].hdr, vecs[v].pay, 1'b0, got, nv, gpar, np);
      chk($sformatf("vec%0d nvalid", v), nv, vecs[v].exp_n);
      chk($sformatf("vec%0d stream", v), int'(got), int'(vecs[v].exp_stream));
      chk($sformatf("vec%0d npar", v),   np, vecs[v].exp_np);
      chk($sformatf("vec%0d par", v),    gpar, vecs[v].exp_par);
      idle(1);
    end

    // Reset in XMIT with three payload bits left; start pulses in HDR/XMIT are ignored.
    start_v = '0; start_v[1] = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      ser_v[1]   = 1'((6 >> (2 - k)) & 1);
      start_v[1] = (k == 1);
      @(posedge clk); #1;
    end
    chk("rstx hdr rg", get_rg(1), 6);
    chk("rstx hdr dc", get_dc(1), 6);
    for (int k = 0; k < 3; k++) begin
      ser_v[1]   = 1'b1;
      start_v[1] = (k == 0);
      @(posedge clk); #1;
      chk($sformatf("rstx xmit%0d ov", k), int'(ov[1]), 1);
    end
    start_v[1] = 1'b0;
    chk("rstx dc before rst", get_dc(1), 3);
    chk("rstx rdy before rst", int'(rdy[1]), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstx ov", int'(ov[1]), 0);
    chk("rstx so", int'(so[1]), 0);
    chk("rstx pb", int'(pb[1]), 0);
    chk("rstx rdy", int'(rdy[1]), 1);
    chk("rstx dc", get_dc(1), 0);
    chk("rstx uc", get_uc(1), 0);
    chk("rstx rg", get_rg(1), 0);
    idle(2);
    run_frame(1, 2, 16'h0003, 1'b0, got, nv, gpar, np);
    chk("post rst stream", int'(got), 3);
    chk("post rst par", gpar, 0);
    idle(1);

    // Start held high: each frame begins on the IDLE cycle right after the previous one.
    run_frame(0, 2, 16'h0002, 1'b1, got, nv, gpar, np);
    chk("held f1 stream", int'(got), 2);
    run_frame(0, 3, 16'h0005, 1'b1, got, nv, gpar, np);
    chk("held f2 stream", int'(got), 5);
    run_frame(2, 0, 16'h0000, 1'b1, got, nv, gpar, np);
    chk("held f3 nvalid", nv, 0);
    idle(1);

    for (int r = 0; r < 40; r++) begin
      int        i, h, exp_par;
      bit        hold;
      bit [15:0] pay;
      i    = $urandom_range(0, 2);
      h    = $urandom_range(0, (1 << lw(i)) - 1);
      pay  = 16'($urandom) & 16'((1 << h) - 1);
      hold = 1'($urandom_range(0, 1));
      run_frame(i, h, pay, hold, got, nv, gpar, np);
      exp_par = 0;
      for (int k = 0; k < h; k++) exp_par ^= int'(pay[k]);
      chk($sformatf("rnd%0d nvalid", r), nv, h);
      chk($sformatf("rnd%0d stream", r), int'(got), int'(pay));
      chk($sformatf("rnd%0d npar", r), np, pe(i) ? 1 : 0);
      if (pe(i)) chk($sformatf("rnd%0d par", r), gpar, exp_par);
      if (!hold || $urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
